hwpe_stream_serialize_ctrl: RTL
===============================

Name: hwpe_stream_serialize_ctrl

Overview:
Job-level sequencer for the `hwpe_stream_serialize` stream serializer. Latches a job (round count, contiguous-packet count), realigns the serializer state, then passes exactly NB_IN_STREAMS*(nb_contig_m1+1)*nb_rounds handshakes on the serialized stream. It then closes the gate and pulses done. It sits between the serializer pop side and the downstream consumer; the data/strb path bypasses it, and only valid/ready are gated. The serializer's clear_serdes_state and first_stream inputs are tied to 0 at integration.

Parameters:
NB_IN_STREAMS, 2, number of serialized input streams (>=1).
CONTIG_LIMIT, 1024, max contiguous packets per stream; sets CW=$clog2(CONTIG_LIMIT).
ROUND_WIDTH, 16, width of round counter/config.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous soft clear
start_i  in  1  job start request (sampled in IDLE only)
nb_rounds_i  in  ROUND_WIDTH  number of full stream rounds in job
nb_contig_m1_i  in  CW  contiguous packets per stream minus one
busy_o  out  1  job in progress (INIT or RUN)
done_o  out  1  one-cycle end-of-job pulse
serdes_clear_o  out  1  drives serializer clear_i
nb_contig_m1_o  out  CW  latched value, drives serializer ctrl nb_contig_m1
cur_stream_o  out  max(1,$clog2(NB_IN_STREAMS))  mirrored stream index
cur_round_o  out  ROUND_WIDTH  completed rounds in current job
in_valid_i  in  1  serializer pop valid
in_ready_o  out  1  serializer pop ready
out_valid_o  out  1  valid to consumer
out_ready_i  in  1  consumer ready

Behaviour:
- Reset state:
  - FSM=IDLE; all counters and latched config = 0.
  - busy_o=0, done_o=0, serdes_clear_o=0, in_ready_o=0, out_valid_o=0.
- FSM states: IDLE, INIT, RUN, DONE.
  - IDLE: on start_i=1, latch nb_rounds_i and nb_contig_m1_i, zero the counters, go to INIT.
  - INIT: exactly one cycle. serdes_clear_o=1 so the serializer counters restart at stream 0, matching the mirror. Next state is DONE if latched nb_rounds==0, else RUN.
  - RUN:
    - out_valid_o = in_valid_i; in_ready_o = out_ready_i. Both are combinational, with zero added latency.
    - hs = in_valid_i & out_ready_i.
    - On hs, contig_q increments. When contig_q==nb_contig_m1, contig_q wraps to 0 and stream_q increments. When stream_q==NB_IN_STREAMS-1, stream_q wraps to 0 and round_q increments.
    - last = (contig_q==nb_contig_m1) & (stream_q==NB_IN_STREAMS-1) & (round_q==nb_rounds-1). hs & last goes to DONE; the counters wrap normally on that cycle.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- Outside RUN: in_ready_o=0 and out_valid_o=0 regardless of inputs; serializer packets are held, never dropped.
- busy_o=1 in INIT and RUN; 0 in IDLE and DONE.
- start_i outside IDLE is ignored and not queued. Config inputs are only sampled on the IDLE→INIT transition.
- nb_contig_m1_o comes from the latched register. It is stable for the whole job and retains its value after DONE.
- cur_stream_o = stream_q; cur_round_o = round_q.
- Arithmetic: all counters are unsigned and compare for equality against latched limits. nb_contig_m1 >= CONTIG_LIMIT is out of contract. NB_IN_STREAMS==1: stream_q is constant 0.
- clear_i, any state:
  - Next cycle: IDLE, counters 0, latched config 0, no done_o pulse.
  - serdes_clear_o is also asserted in the clear_i cycle, so the serializer is cleared together with the controller.
  - clear_i takes priority over start_i in the same cycle.
- Async reset mid-RUN: outputs return to reset values immediately.
- The last handshake and the done_o pulse are in consecutive cycles. A new start_i is accepted no earlier than the cycle after DONE (IDLE).

Test Plan:
- NB=2, m1=0, rounds=1, out_ready=1, in_valid=1: INIT 1 cycle → exactly 2 hs. Then done_o=1 on the following cycle, then IDLE. serdes_clear_o=1 only in INIT.
- NB=2, m1=3, rounds=2: exactly 16 hs. cur_stream_o toggles every 4 hs. cur_round_o goes 0→1 after hs 8 and wraps to 0 at the last hs. done_o follows.
- rounds=0: start → INIT → DONE. done_o asserted 2 cycles after start. out_valid_o never 1; in_ready_o never 1.
- m1=1, rounds=1, out_ready toggling 1010…, in_valid gaps: counters advance only on hs cycles. The job ends after exactly 4 hs; no packet leaks after done.
- clear_i asserted after 3 hs of an 8-hs job: next cycle IDLE, busy_o=0, counters 0, no done_o. A new start runs the full job.
- start_i pulsed during RUN with a different nb_rounds_i: ignored; the original job count completes unchanged.

Source files
------------

// File: rtl/hwpe_stream_serialize_ctrl.sv
// Job sequencer for the stream serializer. It gates valid/ready so that exactly
// NB_IN_STREAMS*(nb_contig_m1+1)*nb_rounds handshakes pass per job, then pulses done.
module hwpe_stream_serialize_ctrl #(
  parameter int unsigned NB_IN_STREAMS = 2,
  parameter int unsigned CONTIG_LIMIT  = 1024,
  parameter int unsigned ROUND_WIDTH   = 16,
  localparam int unsigned CW = $clog2(CONTIG_LIMIT),
  localparam int unsigned SW = (NB_IN_STREAMS > 1) ? $clog2(NB_IN_STREAMS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [ROUND_WIDTH-1:0] nb_rounds_i,
  input  logic [CW-1:0]          nb_contig_m1_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   serdes_clear_o,
  output logic [CW-1:0]          nb_contig_m1_o,
  output logic [SW-1:0]          cur_stream_o,
  output logic [ROUND_WIDTH-1:0] cur_round_o,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [ROUND_WIDTH-1:0] nb_rounds_q, nb_rounds_d;
  logic [CW-1:0]          nb_contig_m1_q, nb_contig_m1_d;
  logic [CW-1:0]          contig_q, contig_d;
  logic [SW-1:0]          stream_q, stream_d;
  logic [ROUND_WIDTH-1:0] round_q, round_d;

  logic hs, last_contig, last_stream, last_round;

  assign hs          = (state_q == RUN) & in_valid_i & out_ready_i;
  assign last_contig = (contig_q == nb_contig_m1_q);
  assign last_stream = (stream_q == SW'(NB_IN_STREAMS - 1));
  assign last_round  = (round_q == nb_rounds_q - ROUND_WIDTH'(1));

  always_comb begin
    state_d        = state_q;
    nb_rounds_d    = nb_rounds_q;
    nb_contig_m1_d = nb_contig_m1_q;
    contig_d       = contig_q;
    stream_d       = stream_q;
    round_d        = round_q;
    unique case (state_q)
      IDLE: if (start_i) begin
        nb_rounds_d    = nb_rounds_i;
        nb_contig_m1_d = nb_contig_m1_i;
        contig_d       = '0;
        stream_d       = '0;
        round_d        = '0;
        state_d        = INIT;
      end
      INIT: state_d = (nb_rounds_q == '0) ? DONE : RUN;
      RUN: if (hs) begin
        // Nested wrap: contig inside stream inside round; the last beat wraps all to 0.
        if (last_contig) begin
          contig_d = '0;
          if (last_stream) begin
            stream_d = '0;
            round_d  = last_round ? '0 : round_q + ROUND_WIDTH'(1);
          end else begin
            stream_d = stream_q + SW'(1);
          end
        end else begin
          contig_d = contig_q + CW'(1);
        end
        if (last_contig && last_stream && last_round) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d        = IDLE;
      nb_rounds_d    = '0;
      nb_contig_m1_d = '0;
      contig_d       = '0;
      stream_d       = '0;
      round_d        = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      nb_rounds_q    <= '0;
      nb_contig_m1_q <= '0;
      contig_q       <= '0;
      stream_q       <= '0;
      round_q        <= '0;
    end else begin
      state_q        <= state_d;
      nb_rounds_q    <= nb_rounds_d;
      nb_contig_m1_q <= nb_contig_m1_d;
      contig_q       <= contig_d;
      stream_q       <= stream_d;
      round_q        <= round_d;
    end
  end

  assign busy_o         = (state_q == INIT) | (state_q == RUN);
  assign done_o         = (state_q == DONE);
  assign serdes_clear_o = (state_q == INIT) | clear_i;
  assign nb_contig_m1_o = nb_contig_m1_q;
  assign cur_stream_o   = stream_q;
  assign cur_round_o    = round_q;
  assign out_valid_o    = (state_q == RUN) & in_valid_i;
  assign in_ready_o     = (state_q == RUN) & out_ready_i;

endmodule
